calc_controller: RTL and testbench
==================================

# calc_controller

Instruction sequencer that consumes the 4-bit one-hot phase vector from the timing ring counter and produces the `calc_done` signal that stops it. Each full ring rotation runs one fetch/decode/execute/writeback cycle of an 8-bit accumulator machine, reading instructions from an external instruction memory. When a HALT instruction retires, the block asserts `calc_done`, which parks the ring counter until the next start.

## Interface
- `DATA_W`, 8: accumulator width.
- `ADDR_W`, 4: PC and instruction-address width.
- `clk` input 1: clock; all state updates on rising edge.
- `clr` input 1: asynchronous, active-high reset.
- `q` input 4: ring-counter phase vector; `1000` → `0100` → `0010` → `0001` → `1000`.
- `imem_addr` output ADDR_W: instruction address, equal to the PC register.
- `imem_data` input 8: instruction at `imem_addr`; combinational read, valid in the same cycle.
- `acc_o` output DATA_W: accumulator.
- `zero_o` output 1: Z flag, set when the last ALU result was 0.
- `carry_o` output 1: C flag, carry for ADDI and borrow for SUBI.
- `calc_done` output 1: HALT retired; held high until `clr`.
- `err` output 1: sticky error flag.

## Operation
- Instruction format: opcode `[7:4]`, imm `[3:0]`. Imm is zero-extended to DATA_W, or truncated/zero-extended to ADDR_W for jumps.
- Opcodes:
  - 0 NOP; 1 LDI; 2 ADDI; 3 SUBI; 4 ANDI; 5 ORI; 6 XORI.
  - 7 SHL: shift left 1, C = bit shifted out. 8 SHR: logical shift right 1, C = bit shifted out.
  - 9 JMP; A JZ (jump if Z = 1); F HALT.
  - B–E are illegal.
- Only ALU ops (1–8) update Z. Only 2, 3, 7 and 8 update C. LDI clears C.
- A phase action fires only on a **transition**: current `q` is valid one-hot, differs from the registered previous `q`, and is the transition expected by the FSM. A frozen `q` does nothing.
  - `1000`→`0100` FETCH: IR ← `imem_data`.
  - `0100`→`0010` DECODE: latch ALU op select, jump and halt flags.
  - `0010`→`0001` EXEC: result and flags into temporary registers.
  - `0001`→`1000` WB: commit acc and flags. PC ← jump target or PC+1, wrapping modulo 2^ADDR_W. HALT → DONE.
- FSM states: WAIT_F, WAIT_D, WAIT_E, WAIT_W, DONE. Reset state is WAIT_F.
- DONE: `calc_done` = 1, PC frozen. All later phase transitions are ignored; the ring makes 1–2 more shifts before stopping. Only `clr` leaves DONE.
- Illegal opcode: executes as NOP and sets `err`.
- Non-one-hot `q`, or a valid but out-of-sequence transition: ignored, sets `err`, and the FSM state is unchanged.
- `clr` mid-instruction: all state is reset immediately. The partial instruction is discarded, with no commit.

## Timing
- Reset values: `imem_addr`=0, `acc_o`=0, `zero_o`=0, `carry_o`=0, `calc_done`=0, `err`=0. The previous-`q` register resets to `1000`, which matches the ring reset value, so no action fires until the ring first shifts.
- Each action is registered on the clock edge where the new `q` is first sampled.
- While the ring runs freely, one instruction retires every 4 clocks.
- `calc_done` rises on the WB edge of HALT. The ring's `go` drops one clock later.
- JZ tests the Z value committed by the previous WB.

## Configuration
- `CALC_ILLEGAL_CHK_EN`:
  - Defined: illegal-opcode, non-one-hot and out-of-sequence detection drive a sticky `err`.
  - Undefined: `err` is tied to 0, detection logic is removed, and illegal opcodes still execute as NOP.

## Structure
- Package `calc_pkg`: opcode localparams, the four phase one-hot constants, and the FSM state enum.
- Sub-module `calc_alu`: purely combinational; takes op, acc, imm, C_in and returns result, Z, C. Instantiated once inside EXEC.

## Test plan
- Program {LDI 5, ADDI 3, HALT}, free-running ring → `acc_o`=8, Z=0, `calc_done` high 12 phase transitions after the first shift.
- {LDI 2, SUBI 3, HALT} → `acc_o`=0xFF, C=1, Z=0.
- {LDI 1, SUBI 1, JZ 5, LDI 7, HALT, HALT at 5} → `acc_o`=0, PC sequence 0,1,2,5; address 3 never fetched.
- Hold `q`=`0010` for 10 clocks mid-instruction, then resume → identical final `acc_o`; no extra actions during the freeze.
- Force `q`=`0110` → `err`=1 with the macro, 0 without; the program result is unchanged once valid phases resume.
- Pulse `clr` while in WAIT_W with pending LDI 9 → all outputs 0 asynchronously; `acc_o` never becomes 9.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcodes, ring-phase constants and sequencer states for the accumulator machine.
package calc_pkg;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpAddi = 4'h2;
  localparam logic [3:0] OpSubi = 4'h3;
  localparam logic [3:0] OpAndi = 4'h4;
  localparam logic [3:0] OpOri  = 4'h5;
  localparam logic [3:0] OpXori = 4'h6;
  localparam logic [3:0] OpShl  = 4'h7;
  localparam logic [3:0] OpShr  = 4'h8;
  localparam logic [3:0] OpJmp  = 4'h9;
  localparam logic [3:0] OpJz   = 4'hA;
  localparam logic [3:0] OpHalt = 4'hF;

  // Ring value whose arrival triggers each phase action.
  localparam logic [3:0] PhFetch  = 4'b0100;
  localparam logic [3:0] PhDecode = 4'b0010;
  localparam logic [3:0] PhExec   = 4'b0001;
  localparam logic [3:0] PhWb     = 4'b1000;

  typedef enum logic [2:0] {
    StWaitF,
    StWaitD,
    StWaitE,
    StWaitW,
    StDone
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OpLdi) && (op <= OpShr);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OpJz) || (op == OpHalt);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: result plus Z and C for one accumulator instruction.
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              c_i,
  output logic [DATA_W-1:0] res_o,
  output logic              z_o,
  output logic              c_o
);

  always_comb begin
    res_o = acc_i;
    c_o   = c_i;
    case (op_i)
      OpLdi: begin
        res_o = imm_i;
        c_o   = 1'b0;
      end
      OpAddi: {c_o, res_o} = {1'b0, acc_i} + {1'b0, imm_i};
      // MSB of the widened difference is the borrow.
      OpSubi: {c_o, res_o} = {1'b0, acc_i} - {1'b0, imm_i};
      OpAndi: res_o = acc_i & imm_i;
      OpOri:  res_o = acc_i | imm_i;
      OpXori: res_o = acc_i ^ imm_i;
      OpShl: begin
        c_o   = acc_i[DATA_W-1];
        res_o = {acc_i[DATA_W-2:0], 1'b0};
      end
      OpShr: begin
        c_o   = acc_i[0];
        res_o = {1'b0, acc_i[DATA_W-1:1]};
      end
      default: ;
    endcase
    z_o = (res_o == '0);
  end

endmodule

// File: rtl/calc_controller.sv
// Ring-phase-driven fetch/decode/execute/writeback sequencer for an 8-bit accumulator machine.
// Define CALC_ILLEGAL_CHK_EN to enable the sticky err flag and its detection logic.
module calc_controller
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [3:0]        q,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  output logic [DATA_W-1:0] acc_o,
  output logic              zero_o,
  output logic              carry_o,
  output logic              calc_done,
  output logic              err
);

  state_e             state_q, state_d;
  logic [3:0]         q_prev_q, q_prev_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [7:0]         ir_q, ir_d;
  logic [3:0]         op_q, op_d;
  logic               jump_q, jump_d, halt_q, halt_d;
  logic [DATA_W-1:0]  res_q, res_d, acc_q, acc_d;
  logic               z_tmp_q, z_tmp_d, c_tmp_q, c_tmp_d;
  logic               zero_q, zero_d, carry_q, carry_d;

  logic               q_onehot, q_edge, fire;
  logic [3:0]         exp_q, exp_prev, opcode;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_z, alu_c;

  assign opcode   = ir_q[7:4];
  assign q_onehot = (q != 4'b0) && ((q & (q - 4'b1)) == 4'b0);
  assign q_edge   = q_onehot && (q != q_prev_q);

  always_comb begin
    exp_q = 4'b0;
    unique case (state_q)
      StWaitF: exp_q = PhFetch;
      StWaitD: exp_q = PhDecode;
      StWaitE: exp_q = PhExec;
      StWaitW: exp_q = PhWb;
      default: exp_q = 4'b0;
    endcase
  end

  // The ring shifts right, so the expected predecessor is the left rotation.
  assign exp_prev = {exp_q[2:0], exp_q[3]};
  assign fire     = q_edge && (q == exp_q) && (q_prev_q == exp_prev);

  calc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op_i (op_q),
    .acc_i(acc_q),
    .imm_i(DATA_W'(ir_q[3:0])),
    .c_i  (carry_q),
    .res_o(alu_res),
    .z_o  (alu_z),
    .c_o  (alu_c)
  );

  always_comb begin
    state_d  = state_q;
    q_prev_d = q_onehot ? q : q_prev_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    op_d     = op_q;
    jump_d   = jump_q;
    halt_d   = halt_q;
    res_d    = res_q;
    z_tmp_d  = z_tmp_q;
    c_tmp_d  = c_tmp_q;
    acc_d    = acc_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    if (fire) begin
      unique case (state_q)
        StWaitF: begin
          ir_d    = imem_data;
          state_d = StWaitD;
        end
        StWaitD: begin
          op_d    = is_legal_op(opcode) ? opcode : OpNop;
          jump_d  = (opcode == OpJmp) || ((opcode == OpJz) && zero_q);
          halt_d  = (opcode == OpHalt);
          state_d = StWaitE;
        end
        StWaitE: begin
          res_d   = alu_res;
          z_tmp_d = alu_z;
          c_tmp_d = alu_c;
          state_d = StWaitW;
        end
        StWaitW: begin
          acc_d   = res_q;
          carry_d = c_tmp_q;
          if (is_alu_op(op_q)) zero_d = z_tmp_q;
          if (halt_q) begin
            state_d = StDone;
          end else begin
            pc_d    = jump_q ? ADDR_W'(ir_q[3:0]) : pc_q + ADDR_W'(1);
            state_d = StWaitF;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= StWaitF;
      q_prev_q <= PhWb;
      pc_q     <= '0;
      ir_q     <= '0;
      op_q     <= OpNop;
      jump_q   <= 1'b0;
      halt_q   <= 1'b0;
      res_q    <= '0;
      z_tmp_q  <= 1'b0;
      c_tmp_q  <= 1'b0;
      acc_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_prev_q <= q_prev_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      op_q     <= op_d;
      jump_q   <= jump_d;
      halt_q   <= halt_d;
      res_q    <= res_d;
      z_tmp_q  <= z_tmp_d;
      c_tmp_q  <= c_tmp_d;
      acc_q    <= acc_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

`ifdef CALC_ILLEGAL_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (!q_onehot) err_d = 1'b1;
    if (q_edge && !fire && (state_q != StDone)) err_d = 1'b1;
    if (fire && (state_q == StWaitD) && !is_legal_op(opcode)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign acc_o     = acc_q;
  assign zero_o    = zero_q;
  assign carry_o   = carry_q;
  assign calc_done = (state_q == StDone);

endmodule

// File: tb/tb_calc_controller.sv
// Directed self-checking bench for calc_controller; the bench plays the ring counter and imem.
module tb_calc_controller;

`ifdef CALC_ILLEGAL_CHK_EN
  localparam int ErrExp = 1;
`else
  localparam int ErrExp = 0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] q;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] acc_o;
  logic       zero_o, carry_o, calc_done, err;
  logic [7:0] mem [16];
  logic [3:0] fetch_log [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         phases;
  int         exp_pcs [4] = '{0, 1, 2, 5};

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  calc_controller #(
    .DATA_W(8),
    .ADDR_W(4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .q        (q),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .acc_o    (acc_o),
    .zero_o   (zero_o),
    .carry_o  (carry_o),
    .calc_done(calc_done),
    .err      (err)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] prog [16]);
    for (int i = 0; i < 16; i++) mem[i] = prog[i];
  endtask

  task automatic do_reset();
    clr = 1'b1;
    q   = 4'b1000;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  // Free-running ring with an optional freeze or non-one-hot glitch after a given shift.
  task automatic run_prog(input int freeze_after, input int freeze_len, input int glitch_after,
                          output int n_shift);
    logic [3:0] saved;
    n_shift = 0;
    fetch_log.delete();
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (calc_done) break;
      if (q == 4'b1000) fetch_log.push_back(imem_addr);
      q       = {q[0], q[3:1]};
      n_shift = n;
      if (n == freeze_after) repeat (freeze_len) @(negedge clk);
      if (n == glitch_after) begin
        saved = q;
        @(negedge clk);
        q = 4'b0110;
        @(negedge clk);
        q = saved;
      end
    end
    // The ring makes one more shift before its go drops.
    q = {q[0], q[3:1]};
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] prog [16];

    // Reset state
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    load(prog);
    do_reset();
    check_eq("rst_addr", 32'(imem_addr), 0);
    check_eq("rst_acc", 32'(acc_o), 0);
    check_eq("rst_zero", 32'(zero_o), 0);
    check_eq("rst_carry", 32'(carry_o), 0);
    check_eq("rst_done", 32'(calc_done), 0);
    check_eq("rst_err", 32'(err), 0);
    // Held at 1000 after reset: nothing may fire
    repeat (4) @(negedge clk);
    check_eq("idle_addr", 32'(imem_addr), 0);

    // LDI 5; ADDI 3; HALT
    prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'hF0;
    load(prog);
    do_reset();
    run_prog(0, 0, 0, phases);
    check_eq("add_phases", phases, 12);
    check_eq("add_acc", 32'(acc_o), 8);
    check_eq("add_zero", 32'(zero_o), 0);
    check_eq("add_carry", 32'(carry_o), 0);
    check_eq("add_done", 32'(calc_done), 1);
    check_eq("add_err", 32'(err), 0);
    check_eq("add_pc_frozen", 32'(imem_addr), 2);

    // Same program, q frozen at 0010 mid-instruction
    do_reset();
    run_prog(6, 10, 0, phases);
    check_eq("frz_phases", phases, 12);
    check_eq("frz_acc", 32'(acc_o), 8);
    check_eq("frz_err", 32'(err), 0);

    // Same program, q forced to 0110 for one clock
    do_reset();
    run_prog(0, 0, 5, phases);
    check_eq("glt_acc", 32'(acc_o), 8);
    check_eq("glt_done", 32'(calc_done), 1);
    check_eq("glt_err", 32'(err), ErrExp);

    // LDI 2; SUBI 3; HALT -> borrow
    prog[0] = 8'h12; prog[1] = 8'h33; prog[2] = 8'hF0;
    load(prog);
    do_reset();
    run_prog(0, 0, 0, phases);
    check_eq("sub_acc", 32'(acc_o), 8'hFF);
    check_eq("sub_carry", 32'(carry_o), 1);
    check_eq("sub_zero", 32'(zero_o), 0);

    // LDI 1; SUBI 1; JZ 5; LDI 7; HALT; HALT
    prog[0] = 8'h11; prog[1] = 8'h31; prog[2] = 8'hA5;
    prog[3] = 8'h17; prog[4] = 8'hF0; prog[5] = 8'hF0;
    load(prog);
    do_reset();
    run_prog(0, 0, 0, phases);
    check_eq("jz_acc", 32'(acc_o), 0);
    check_eq("jz_zero", 32'(zero_o), 1);
    check_eq("jz_phases", phases, 16);
    check_eq("jz_nfetch", fetch_log.size(), 4);
    for (int i = 0; i < 4 && i < fetch_log.size(); i++)
      check_eq($sformatf("jz_pc%0d", i), 32'(fetch_log[i]), exp_pcs[i]);

    // LDI 12; JMP 4; junk; junk; ORI 3; SHL; ANDI 6; SHR; SHR; XORI 1; HALT
    for (int i = 0; i < 16; i++) prog[i] = 8'h1F;
    prog[0] = 8'h1C; prog[1] = 8'h94; prog[4] = 8'h53; prog[5] = 8'h70;
    prog[6] = 8'h46; prog[7] = 8'h80; prog[8] = 8'h80; prog[9] = 8'h61;
    prog[10] = 8'hF0;
    load(prog);
    do_reset();
    run_prog(0, 0, 0, phases);
    check_eq("mix_phases", phases, 36);
    check_eq("mix_acc", 32'(acc_o), 0);
    check_eq("mix_zero", 32'(zero_o), 1);
    check_eq("mix_carry", 32'(carry_o), 1);

    // LDI 3; illegal B0; ADDI 1; HALT
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h13; prog[1] = 8'hB0; prog[2] = 8'h21; prog[3] = 8'hF0;
    load(prog);
    do_reset();
    run_prog(0, 0, 0, phases);
    check_eq("ill_acc", 32'(acc_o), 4);
    check_eq("ill_phases", phases, 16);
    check_eq("ill_err", 32'(err), ErrExp);

    // LDI 5; LDI 9; HALT with clr pulsed while LDI 9 waits for writeback
    prog[0] = 8'h15; prog[1] = 8'h19; prog[2] = 8'hF0;
    load(prog);
    do_reset();
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      q = {q[0], q[3:1]};
    end
    @(posedge clk);
    #2;
    check_eq("clr_pre_acc", 32'(acc_o), 5);
    check_eq("clr_pre_addr", 32'(imem_addr), 1);
    clr = 1'b1;
    #1;
    check_eq("clr_async_acc", 32'(acc_o), 0);
    check_eq("clr_async_addr", 32'(imem_addr), 0);
    check_eq("clr_async_done", 32'(calc_done), 0);
    @(negedge clk);
    q   = 4'b1000;
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("clr_post_acc", 32'(acc_o), 0);
    check_eq("clr_post_carry", 32'(carry_o), 0);
    check_eq("clr_post_err", 32'(err), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
